axi_mm_to_axis_burst: RTL and testbench
=======================================

# axi_mm_to_axis_burst

Burst-read DMA engine: reads a contiguous block of LENGTH beats from AXI4 memory starting at BASE_ADDR and emits it as one AXI Stream packet (TLAST on the final beat). It is the read-side counterpart of the stream-to-memory burst writer, sharing its START/BUSY/DONE control style. It sits between a memory-mapped slave (DDR/BRAM controller) and a downstream stream consumer, with one read burst outstanding at a time.

## Interface
- AXI_DATA_WIDTH, 32: AXI MM and AXIS data width in bits (8..1024, power of 2)
- AXI_ADDR_WIDTH, 32: AXI address width
- MAX_BURST_LEN, 16: maximum beats per AR burst (1..256); BASE_ADDR must be aligned to MAX_BURST_LEN*AXI_DATA_WIDTH/8, and that product must be ≤4096 (guarantees no 4 KB crossing)
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- BASE_ADDR  in  AXI_ADDR_WIDTH  start address, sampled on accepted START
- LENGTH  in  16  transfer length in beats, sampled on accepted START
- START  in  1  start pulse; honoured only when BUSY=0
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- ERROR  out  1  sticky RRESP error flag for the current/last transfer
- m_axi_araddr  out  AXI_ADDR_WIDTH; m_axi_arlen  out  8; m_axi_arsize  out  3 (= log2(bytes), constant); m_axi_arburst  out  2 (= 2'b01 INCR, constant); m_axi_arprot  out  3 (= 3'b000); m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_rdata  in  AXI_DATA_WIDTH; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1
- m_axis_tdata  out  AXI_DATA_WIDTH; m_axis_tlast  out  1; m_axis_tvalid  out  1; m_axis_tready  in  1

## Operation
- States: IDLE, ADDR, DATA, FINISH.
- IDLE: BUSY=0. START=1 latches BASE_ADDR→addr, LENGTH→remaining, clears ERROR. LENGTH≠0 → ADDR; LENGTH=0 → FINISH (no AXI traffic).
- ADDR: arvalid=1, araddr=addr, arlen=min(remaining, MAX_BURST_LEN)-1, held stable until arready. On AR handshake: burst_cnt←arlen+1, remaining←remaining-(arlen+1), addr←addr+(arlen+1)*bytes (mod 2^AXI_ADDR_WIDTH) → DATA.
- DATA: rready=1 whenever output buffer has a free slot. Each R handshake writes {rdata, tlast} into buffer, tlast=1 only on final beat of transfer (remaining=0 and burst_cnt=1). burst_cnt decrements per beat. Last beat of burst: remaining≠0 → ADDR; remaining=0 → FINISH once buffer has drained (final AXIS handshake done).
- rlast is not trusted for counting; beat count governs. rlast mismatch with burst_cnt=1 sets ERROR (when checking enabled).
- FINISH: DONE=1 for exactly one cycle, BUSY=1 this cycle → IDLE.
- Output buffer: 2-entry skid, registered AXIS outputs; tdata/tlast stable while tvalid=1 and tready=0.
- START while BUSY=1 ignored.

## Timing
- Reset values: BUSY=0, DONE=0, ERROR=0, arvalid=0, rready=0, tvalid=0, tlast=0; araddr/arlen/tdata=0.
- START accepted in cycle N → arvalid=1 in cycle N+1; BUSY=1 from N+1.
- R beat accepted cycle N → tvalid in cycle N+1 (1-cycle latency).
- Full throughput: with arready/rvalid/tready held high, one beat per cycle within a burst; one AR bubble cycle between bursts.
- Buffer full: rready=0 the same cycle the second slot is occupied and not draining; no beat dropped. Simultaneous push/pop on full buffer permitted.
- Final AXIS handshake in cycle N → DONE=1 in N+1, BUSY=0 in N+2.
- ARESETn low at any time: immediate return to IDLE and reset values; outstanding AXI transactions abandoned (system resets the slave together).

## Configuration
- AXI_MM_TO_AXIS_RRESP_CHECK_EN defined: any accepted beat with rresp≠2'b00, or rlast inconsistent with beat count, sets ERROR (sticky until next accepted START); transfer still completes normally.
- Not defined: ERROR tied 0, rresp/rlast ignored.

## Test plan
- BASE_ADDR=0x1000, LENGTH=16, MAX_BURST_LEN=16, all ready high → one AR (araddr 0x1000, arlen 15), 16 AXIS beats, tlast on beat 16 only, DONE once.
- LENGTH=40 → ARs at 0x1000/0x1040/0x1080 with arlen 15/15/7, 40 beats in memory order, single tlast.
- tready toggled randomly (50%) with 3-cycle hold-offs → no data loss/duplication, tdata stable while stalled, rready drops when buffer full.
- LENGTH=0 → no arvalid, DONE pulse one cycle after START, BUSY falls next cycle.
- With macro: rresp=2'b10 on beat 5 of 16 → ERROR=1 at DONE, all 16 beats delivered; next START clears ERROR.
- ARESETn asserted mid-burst (beat 7) → all outputs at reset values immediately; subsequent START with LENGTH=4 completes cleanly.

Source files
------------

// File: rtl/axi_mm_to_axis_burst.sv
// axi_mm_to_axis_burst
// Burst-read DMA: fetches LENGTH beats from AXI4 memory starting at BASE_ADDR
// and emits them as a single AXI Stream packet with TLAST on the final beat.
// One AR burst is outstanding at a time, and bursts never cross a 4 KB page.
// Optional feature macro: AXI_MM_TO_AXIS_RRESP_CHECK_EN. When defined, a bad
// RRESP or a misplaced RLAST sets the sticky ERROR flag. When undefined,
// ERROR is tied low.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for START; BUSY low
// ADDR   | AR request presented, held stable until arready
// DATA   | accepting R beats into the skid buffer; after the last beat,
//        | wait here until the final stream beat has been handed off
// FINISH | one-cycle DONE pulse, then back to IDLE

module axi_mm_to_axis_burst #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [15:0]               LENGTH,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERROR,

    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,

    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int BYTES     = AXI_DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FINISH} state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [15:0]               remaining;
    logic [8:0]                burst_cnt;

    logic [AXI_DATA_WIDTH-1:0] sk_data;
    logic                      sk_last;
    logic                      sk_valid;

    logic                      r_fire;
    logic                      t_fire;
    logic                      beat_last;
    logic [8:0]                ar_beats;

    // Clamp the beats left to one burst and express it as an AXI length code.
    function automatic logic [7:0] burst_arlen(input logic [15:0] beats);
        if (beats > 16'(MAX_BURST_LEN))
            return 8'(MAX_BURST_LEN - 1);
        return 8'(beats - 16'd1);
    endfunction

    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arprot  = 3'b000;

    assign r_fire    = m_axi_rvalid && m_axi_rready;
    assign t_fire    = m_axis_tvalid && m_axis_tready;
    assign beat_last = (remaining == 16'd0) && (burst_cnt == 9'd1);
    assign ar_beats  = {1'b0, m_axi_arlen} + 9'd1;

    // A beat is only taken while the skid slot is empty, so the two-entry
    // buffer can never overflow even if the stream side stalls for a long time.
    assign m_axi_rready = (state == DATA) && (burst_cnt != 9'd0) && !sk_valid;

    // Sequencer: START handling, AR generation, beat counting, DONE/BUSY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            burst_cnt     <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        addr      <= BASE_ADDR;
                        remaining <= LENGTH;
                        BUSY      <= 1'b1;
                        if (LENGTH != 16'd0) begin
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= BASE_ADDR;
                            m_axi_arlen   <= burst_arlen(LENGTH);
                            state         <= ADDR;
                        end else begin
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        burst_cnt     <= ar_beats;
                        remaining     <= remaining - 16'(ar_beats);
                        addr          <= addr + (AXI_ADDR_WIDTH'(ar_beats) << SIZE_LOG2);
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (r_fire) begin
                        burst_cnt <= burst_cnt - 9'd1;
                        if (burst_cnt == 9'd1 && remaining != 16'd0) begin
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= addr;
                            m_axi_arlen   <= burst_arlen(remaining);
                            state         <= ADDR;
                        end
                    end
                    // The packet is complete only once its TLAST beat has left.
                    if (t_fire && m_axis_tlast) begin
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry skid buffer. The output register is the head and sk_* is the
    // overflow slot. The head reloads whenever it is empty or being drained.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            sk_valid      <= 1'b0;
            sk_data       <= '0;
            sk_last       <= 1'b0;
        end else if (!m_axis_tvalid || m_axis_tready) begin
            if (sk_valid) begin
                m_axis_tdata  <= sk_data;
                m_axis_tlast  <= sk_last;
                m_axis_tvalid <= 1'b1;
                sk_valid      <= 1'b0;
            end else if (r_fire) begin
                m_axis_tdata  <= m_axi_rdata;
                m_axis_tlast  <= beat_last;
                m_axis_tvalid <= 1'b1;
            end else begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end else if (r_fire) begin
            sk_data  <= m_axi_rdata;
            sk_last  <= beat_last;
            sk_valid <= 1'b1;
        end
    end

`ifdef AXI_MM_TO_AXIS_RRESP_CHECK_EN
    logic error_q;

    // Sticky error: a bad response or an RLAST that disagrees with our own
    // beat count. The transfer still runs to completion.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            error_q <= 1'b0;
        else if (state == IDLE && START)
            error_q <= 1'b0;
        else if (r_fire && ((m_axi_rresp != 2'b00) ||
                            (m_axi_rlast != (burst_cnt == 9'd1))))
            error_q <= 1'b1;
    end

    assign ERROR = error_q;
`else
    logic unused_resp_bits;

    assign unused_resp_bits = ^{m_axi_rresp, m_axi_rlast};
    assign ERROR            = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mm_to_axis_burst.sv
// Testbench for axi_mm_to_axis_burst: behavioural AXI read slave, scoreboard
// of expected stream beats and AR requests, DONE/BUSY timing expectations.
module tb_axi_mm_to_axis_burst;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MBL = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [AW-1:0] BASE_ADDR;
    logic [15:0]   LENGTH;
    logic          START;
    logic          BUSY, DONE, ERROR;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;

    always #5 ACLK = ~ACLK;

    axi_mm_to_axis_burst #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_BURST_LEN(MBL)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    typedef struct packed {logic [31:0] data; logic last;}  beat_t;
    typedef struct packed {logic [31:0] addr; logic [7:0] len_m1;} ar_t;

    beat_t exp_q[$];
    ar_t   exp_ar[$];
    ar_t   rq[$];

    int n_cmp = 0;
    int n_mis = 0;

    int          step_no = 0;
    int          start_step, done_step, done_cnt = 0;
    int          beats_out;
    int          beat_global = 0;
    int          err_beat = -1;
    logic        err_exp = 1'b0;
    logic        start_pending = 1'b0;
    logic [31:0] st_base;
    int          st_len;
    int          tready_mode = 0;
    int          hold = 0;
    int          rv_block = 0;
    logic [31:0] r_addr;
    int          r_left = 0;
    logic        done_due = 1'b0, busy_low_due = 1'b0, arv_due = 1'b0;
    logic        prev_tv = 1'b0, prev_tr = 1'b0, prev_tl = 1'b0;
    logic [31:0] prev_td = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, step_no);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic push_expect(input logic [31:0] base, input int len);
        beat_t       b;
        ar_t         r;
        int          rem, n;
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            b.data = mem_word(base + 32'(i * 4));
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
        rem = len;
        a   = base;
        while (rem > 0) begin
            n        = (rem > MBL) ? MBL : rem;
            r.addr   = a;
            r.len_m1 = 8'(n - 1);
            exp_ar.push_back(r);
            a   = a + 32'(n * 4);
            rem = rem - n;
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_busy",    BUSY, 0);
        check_val("rst_done",    DONE, 0);
        check_val("rst_error",   ERROR, 0);
        check_val("rst_arvalid", m_axi_arvalid, 0);
        check_val("rst_rready",  m_axi_rready, 0);
        check_val("rst_tvalid",  m_axis_tvalid, 0);
        check_val("rst_tlast",   m_axis_tlast, 0);
        check_val("rst_araddr",  m_axi_araddr, 0);
        check_val("rst_arlen",   m_axi_arlen, 0);
        check_val("rst_tdata",   m_axis_tdata, 0);
    endtask

    // One clock: drive inputs just after the falling edge, then look at the
    // settled handshakes that the next rising edge will complete.
    task automatic step();
        ar_t   cur;
        beat_t e;
        logic  d_exp;
        @(negedge ACLK);
        step_no++;

        if (tready_mode == 0) begin
            m_axis_tready = 1'b1;
        end else if (hold > 0) begin
            m_axis_tready = 1'b0;
            hold--;
        end else begin
            m_axis_tready = 1'($urandom_range(0, 1));
            if (!m_axis_tready && $urandom_range(0, 3) == 0) hold = 3;
        end

        if (start_pending) begin
            START     = 1'b1;
            BASE_ADDR = st_base;
            LENGTH    = 16'(st_len);
        end else begin
            START = 1'b0;
        end

        if (r_left == 0 && rq.size() > 0) begin
            cur    = rq.pop_front();
            r_addr = cur.addr;
            r_left = int'(cur.len_m1) + 1;
        end
        if (r_left > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = mem_word(r_addr);
            m_axi_rlast  = (r_left == 1);
            m_axi_rresp  = (beat_global == err_beat) ? 2'b10 : 2'b00;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
        end

        #1;

        if (busy_low_due) begin
            busy_low_due = 1'b0;
            check_val("busy_fall", BUSY, 0);
        end
        d_exp    = done_due;
        done_due = 1'b0;
        check_val("done", DONE, d_exp);
        if (d_exp) begin
            done_cnt++;
            done_step    = step_no;
            busy_low_due = 1'b1;
            check_val("done_busy", BUSY, 1);
            check_val("done_all_beats", exp_q.size(), 0);
            check_val("done_all_ars", exp_ar.size(), 0);
            check_val("error_at_done", ERROR, err_exp);
        end
        if (arv_due) begin
            arv_due = 1'b0;
            check_val("arvalid_after_start", m_axi_arvalid, 1);
            check_val("busy_after_start", BUSY, 1);
            check_val("error_cleared", ERROR, 0);
        end

        if (START && !BUSY) begin
            push_expect(st_base, st_len);
            start_pending = 1'b0;
            start_step    = step_no;
            beats_out     = 0;
            if (st_len == 0) done_due = 1'b1;
            else             arv_due  = 1'b1;
        end

        if (m_axi_arvalid && m_axi_arready) begin
            if (exp_ar.size() == 0) begin
                check_val("ar_unexpected", 1, 0);
            end else begin
                cur = exp_ar.pop_front();
                check_val("araddr", m_axi_araddr, cur.addr);
                check_val("arlen", m_axi_arlen, cur.len_m1);
                check_val("arsize", m_axi_arsize, 3'd2);
                check_val("arburst", m_axi_arburst, 2'b01);
                cur.addr   = m_axi_araddr;
                cur.len_m1 = m_axi_arlen;
                rq.push_back(cur);
            end
        end

        if (m_axi_rvalid && m_axi_rready) begin
            r_addr = r_addr + 32'd4;
            r_left--;
            beat_global++;
        end else if (m_axi_rvalid) begin
            rv_block++;
        end

        if (prev_tv && !prev_tr) begin
            check_val("hold_tvalid", m_axis_tvalid, 1);
            check_val("hold_tdata", m_axis_tdata, prev_td);
            check_val("hold_tlast", m_axis_tlast, prev_tl);
        end

        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check_val("axis_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("tdata", m_axis_tdata, e.data);
                check_val("tlast", m_axis_tlast, e.last);
            end
            beats_out++;
            if (m_axis_tlast) done_due = 1'b1;
        end

        prev_tv = m_axis_tvalid;
        prev_tr = m_axis_tready;
        prev_td = m_axis_tdata;
        prev_tl = m_axis_tlast;
    endtask

    task automatic run_xfer(input logic [31:0] base, input int len);
        int target;
        int budget;
        target        = done_cnt + 1;
        budget        = 3000;
        st_base       = base;
        st_len        = len;
        start_pending = 1'b1;
        while (done_cnt < target && budget > 0) begin
            step();
            budget--;
        end
        if (done_cnt < target) check_val("timeout_done", 0, 1);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        ARESETn       = 1'b0;
        START         = 1'b0;
        BASE_ADDR     = '0;
        LENGTH        = '0;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axis_tready = 1'b1;
        #12;
        check_reset_outputs();
        step();
        step();
        ARESETn = 1'b1;
        step();

        // Single full burst, all ready: 19 cycles from START to DONE.
        run_xfer(32'h1000, 16);
        check_val("lat_16", done_step - start_step, 19);

        // Three bursts 16/16/8 with one AR bubble between each.
        run_xfer(32'h1000, 40);
        check_val("lat_40", done_step - start_step, 45);

        // Random stream backpressure with hold-offs.
        tready_mode = 1;
        rv_block    = 0;
        run_xfer(32'h2000, 40);
        check_val("rready_backpressure", rv_block > 0, 1);
        tready_mode = 0;

        // Zero length: no AR traffic, DONE one cycle after START.
        run_xfer(32'h2400, 0);
        check_val("lat_0", done_step - start_step, 1);

        // Bad response on beat 5: flagged only when checking is built in.
        err_beat = beat_global + 4;
`ifdef AXI_MM_TO_AXIS_RRESP_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        run_xfer(32'h3000, 16);
        err_beat = -1;
        err_exp  = 1'b0;

        // Next START clears the sticky flag.
        run_xfer(32'h3400, 3);

        // Reset in the middle of a burst.
        st_base       = 32'h4000;
        st_len        = 16;
        start_pending = 1'b1;
        budget        = 200;
        beats_out     = 0;
        while (!(BUSY && beats_out >= 7) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check_val("timeout_beat7", 0, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_ar.delete();
        rq.delete();
        r_left       = 0;
        done_due     = 1'b0;
        busy_low_due = 1'b0;
        arv_due      = 1'b0;
        prev_tv      = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
        step();
        run_xfer(32'h5000, 4);
        check_val("lat_4", done_step - start_step, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
